// File: rtl/chunk_shift_seq.sv
// Sequential chunk shifter: moves a CHUNKS x CHUNK_W word by one chunk per clock behind a valid/ready handshake.
// Optional rotate mode is built only when CHUNK_SHIFT_ROTATE_EN is defined; otherwise in_rot is ignored.
//
// state  | meaning
// IDLE   | ready for a request; captures operand, direction, fill and count on in_valid
// BUSY   | one chunk move per cycle until the remaining count reaches zero
// DONE   | result held; out_valid rises one cycle after entry, leaves on out_ready
module chunk_shift_seq #(
    parameter int CHUNK_W = 5,
    parameter int CHUNKS  = 10,
    parameter int SHIFT_W = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHUNK_W*CHUNKS-1:0]   in_data,
    input  logic [SHIFT_W-1:0]          in_shift,
    input  logic                        in_dir,
    input  logic                        in_rot,
    input  logic [CHUNK_W-1:0]          fill,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHUNK_W*CHUNKS-1:0]   out_data,
    output logic                        out_range_ok,
    output logic                        busy
);

    localparam int                 DATA_W   = CHUNK_W * CHUNKS;
    localparam logic [SHIFT_W-1:0] CHUNKS_S = SHIFT_W'(CHUNKS);
    localparam logic [SHIFT_W-1:0] CNT_ONE  = SHIFT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [SHIFT_W-1:0]   cnt_q, cnt_d;
    logic                 dir_q, dir_d;
    logic [CHUNK_W-1:0]   fill_q, fill_d;
    logic                 range_ok_q, range_ok_d;
    logic                 out_valid_q, out_valid_d;
    logic                 handshake;
    logic                 rot_in;
    logic [CHUNK_W-1:0]   chunk_in;

`ifdef CHUNK_SHIFT_ROTATE_EN
    logic rot_q, rot_d;

    assign rot_in   = in_rot;
    assign chunk_in = rot_q ? (dir_q ? data_q[DATA_W-1 -: CHUNK_W] : data_q[CHUNK_W-1:0])
                            : fill_q;
`else
    logic unused_rot;

    assign unused_rot = in_rot;
    assign rot_in     = 1'b0;
    assign chunk_in   = fill_q;
`endif

    assign handshake = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        fill_d      = fill_q;
        range_ok_d  = range_ok_q;
        out_valid_d = 1'b0;
`ifdef CHUNK_SHIFT_ROTATE_EN
        rot_d       = rot_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d     = in_data;
                    dir_d      = in_dir;
                    fill_d     = fill;
`ifdef CHUNK_SHIFT_ROTATE_EN
                    rot_d      = rot_in;
`endif
                    range_ok_d = rot_in || (in_shift < CHUNKS_S);
                    // rotate counts are taken as-is; fill counts saturate at a full word
                    if (rot_in || (in_shift < CHUNKS_S)) begin
                        cnt_d = in_shift;
                    end else begin
                        cnt_d = CHUNKS_S;
                    end
                    state_d = (cnt_d == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (dir_q) begin
                    data_d = {data_q[DATA_W-CHUNK_W-1:0], chunk_in};
                end else begin
                    data_d = {chunk_in, data_q[DATA_W-1:CHUNK_W]};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // out_valid is registered, so it rises one cycle after DONE is entered
                out_valid_d = !handshake;
                if (handshake) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            fill_q      <= '0;
            range_ok_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef CHUNK_SHIFT_ROTATE_EN
            rot_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            fill_q      <= fill_d;
            range_ok_q  <= range_ok_d;
            out_valid_q <= out_valid_d;
`ifdef CHUNK_SHIFT_ROTATE_EN
            rot_q       <= rot_d;
`endif
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign busy         = (state_q == S_BUSY);
    assign out_valid    = out_valid_q;
    assign out_data     = data_q;
    assign out_range_ok = range_ok_q;

endmodule

// File: tb/tb_chunk_shift_seq.sv
// Bench for chunk_shift_seq: chunk-array reference model checked every cycle, plus literal
// expectations for the directed vectors. Honours CHUNK_SHIFT_ROTATE_EN like the design.
module tb_chunk_shift_seq;

    localparam int CW = 5;
    localparam int CH = 10;
    localparam int SW = 4;
    localparam int DW = CW * CH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_shift;
    logic          in_dir;
    logic          in_rot;
    logic [CW-1:0] fill;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_range_ok;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    chunk_shift_seq #(.CHUNK_W(CW), .CHUNKS(CH), .SHIFT_W(SW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_shift     (in_shift),
        .in_dir       (in_dir),
        .in_rot       (in_rot),
        .fill         (fill),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_range_ok (out_range_ok),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: result chunk k is read from source chunk k+n (right) or k-n (left).
    function automatic logic [DW-1:0] model_shift(input logic [DW-1:0] d, input int sh,
                                                  input logic dir, input logic rot,
                                                  input logic [CW-1:0] f);
        logic [CW-1:0] c [CH];
        logic [CW-1:0] r [CH];
        logic [DW-1:0] res;
        int n;
        for (int i = 0; i < CH; i++) c[i] = d[i*CW +: CW];
        n = (sh > CH) ? CH : sh;
        for (int k = 0; k < CH; k++) begin
            if (rot) begin
                if (!dir) r[k] = c[(k + sh) % CH];
                else      r[k] = c[(k - (sh % CH) + CH) % CH];
            end else begin
                r[k] = f;
                if (!dir && (k + n < CH)) r[k] = c[k + n];
                if (dir && (k - n >= 0))  r[k] = c[k - n];
            end
        end
        res = '0;
        for (int i = 0; i < CH; i++) res[i*CW +: CW] = r[i];
        return res;
    endfunction

    bit            m_active = 1'b0;
    int            m_cyc    = 0;
    int            m_lat    = 0;
    logic [DW-1:0] m_data   = '0;
    logic          m_rok    = 1'b1;

    always @(negedge clk) begin
        bit   exp_ov;
        logic rot_eff;
        int   sh;
        if (!rst_n) begin
            m_active = 1'b0;
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_range_ok", out_range_ok, 1);
            check("rst_busy", busy, 0);
        end else begin
            exp_ov = m_active && (m_cyc >= m_lat);
            check("in_ready", in_ready, !m_active);
            check("out_valid", out_valid, exp_ov);
            check("busy", busy, m_active && (m_cyc < m_lat - 1));
            if (exp_ov) begin
                check("out_data", out_data, m_data);
                check("out_range_ok", out_range_ok, m_rok);
            end
            if (!m_active) begin
                if (in_valid) begin
`ifdef CHUNK_SHIFT_ROTATE_EN
                    rot_eff = in_rot;
`else
                    rot_eff = 1'b0;
`endif
                    sh       = int'(in_shift);
                    m_active = 1'b1;
                    m_cyc    = 0;
                    m_data   = model_shift(in_data, sh, in_dir, rot_eff, fill);
                    m_rok    = rot_eff || (sh < CH);
                    m_lat    = 1 + (rot_eff ? sh : ((sh > CH) ? CH : sh));
                end
            end else if (exp_ov && out_ready) begin
                m_active = 1'b0;
            end else begin
                m_cyc++;
            end
        end
    end

    task automatic run_txn(input string tag, input logic [DW-1:0] d, input int sh,
                           input logic dir, input logic rot, input logic [CW-1:0] f,
                           input logic [DW-1:0] lit_d, input logic lit_rok,
                           input int lit_lat, input int hold);
        int lat;
        @(posedge clk); #1;
        in_data  = d;
        in_shift = sh[SW-1:0];
        in_dir   = dir;
        in_rot   = rot;
        fill     = f;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_shift = ~sh[SW-1:0];
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_timeout"}, out_valid, 1);
        check({tag, "_latency"}, lat, lit_lat);
        check({tag, "_data"}, out_data, lit_d);
        check({tag, "_range_ok"}, out_range_ok, lit_rok);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check({tag, "_hold_in_ready"}, in_ready, 0);
            check({tag, "_hold_data"}, out_data, lit_d);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_out_valid"}, out_valid, 0);
        check({tag, "_post_in_ready"}, in_ready, 1);
    endtask

    logic [DW-1:0] op;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_dir    = 1'b0;
        in_rot    = 1'b0;
        fill      = '0;
        out_ready = 1'b0;
        for (int i = 0; i < CH; i++) op[i*CW +: CW] = CW'(i);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_txn("right3", op, 3, 1'b0, 1'b0, 5'h1F,
                {5'h1F, 5'h1F, 5'h1F, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3}, 1'b1, 4, 5);
        run_txn("left2", op, 2, 1'b1, 1'b0, 5'h00,
                {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0}, 1'b1, 3, 0);
        run_txn("shift0", op, 0, 1'b0, 1'b0, 5'h1F, op, 1'b1, 1, 1);
`ifdef CHUNK_SHIFT_ROTATE_EN
        run_txn("rotr12", op, 12, 1'b0, 1'b1, 5'h0A,
                {5'd1, 5'd0, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2}, 1'b1, 13, 0);
        run_txn("rotl3", op, 3, 1'b1, 1'b1, 5'h11,
                {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'd9, 5'd8, 5'd7}, 1'b1, 4, 0);
`else
        run_txn("rotr12", op, 12, 1'b0, 1'b1, 5'h0A, {10{5'h0A}}, 1'b0, 11, 0);
        run_txn("rotl3", op, 3, 1'b1, 1'b1, 5'h11,
                {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'h11, 5'h11, 5'h11}, 1'b1, 4, 0);
`endif
        run_txn("fill11", op, 11, 1'b0, 1'b0, 5'h15, {10{5'h15}}, 1'b0, 11, 2);
        run_txn("left10", op, 10, 1'b1, 1'b0, 5'h03, {10{5'h03}}, 1'b0, 11, 0);
        run_txn("right9", op, 9, 1'b0, 1'b0, 5'h1E, {{9{5'h1E}}, 5'd9}, 1'b1, 10, 0);

        // abort a right shift of 8 three cycles into BUSY
        @(posedge clk); #1;
        in_data  = op;
        in_shift = 4'd8;
        in_dir   = 1'b0;
        in_rot   = 1'b0;
        fill     = 5'h07;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_range_ok", out_range_ok, 1);
        check("abort_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_txn("after_rst", op, 3, 1'b0, 1'b0, 5'h1F,
                {5'h1F, 5'h1F, 5'h1F, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3}, 1'b1, 4, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
